// File: rtl/store_queue_if.sv
// Store-queue handshake bundle: MEM-stage store port, data-memory write port and status.
// The master drives stores and memory acks; the slave is the queue.
interface store_queue_if;
  logic        st_valid_i;
  logic        st_ready_o;
  logic [31:0] st_addr_i;
  logic [31:0] st_data_i;
  logic [1:0]  st_size_i;
  logic        dm_req_o;
  logic        dm_ack_i;
  logic [31:0] dm_addr_o;
  logic [3:0]  dm_we_o;
  logic [31:0] dm_wdata_o;
  logic        sq_empty_o;
  logic [4:0]  sq_count_o;
  logic        st_ades_o;
  logic [31:0] st_badvaddr_o;

  modport master (
    output st_valid_i, st_addr_i, st_data_i, st_size_i, dm_ack_i,
    input  st_ready_o, dm_req_o, dm_addr_o, dm_we_o, dm_wdata_o,
           sq_empty_o, sq_count_o, st_ades_o, st_badvaddr_o
  );

  modport slave (
    input  st_valid_i, st_addr_i, st_data_i, st_size_i, dm_ack_i,
    output st_ready_o, dm_req_o, dm_addr_o, dm_we_o, dm_wdata_o,
           sq_empty_o, sq_count_o, st_ades_o, st_badvaddr_o
  );
endinterface

// File: rtl/store_queue.sv
// Post-MEM store buffer: formats sb/sh/sw into byte-swapped memory lanes and drains them in FIFO order.
// Optional misaligned-store trap enabled by defining ST_ALIGN_CHK_EN.
module store_queue #(
  parameter int unsigned DEPTH = 4
) (
  input logic         clk,
  input logic         rst,
  store_queue_if.slave sq
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = 5;

  typedef struct packed {
    logic [29:0] word_addr;
    logic [3:0]  we;
    logic [31:0] wdata;
  } sq_entry_t;

  // Lane formatting; address offset 0 lives in lane [31:24].
  function automatic sq_entry_t format_store(input logic [31:0] addr,
                                             input logic [31:0] data,
                                             input logic [1:0]  size);
    sq_entry_t e;
    e           = '0;
    e.word_addr = addr[31:2];
    case (size)
      2'b00: begin
        case (addr[1:0])
          2'b00:   begin e.we = 4'b1000; e.wdata[31:24] = data[7:0]; end
          2'b01:   begin e.we = 4'b0100; e.wdata[23:16] = data[7:0]; end
          2'b10:   begin e.we = 4'b0010; e.wdata[15:8]  = data[7:0]; end
          default: begin e.we = 4'b0001; e.wdata[7:0]   = data[7:0]; end
        endcase
      end
      2'b01: begin
        if (addr[1]) begin
          e.we          = 4'b0011;
          e.wdata[15:0] = {data[7:0], data[15:8]};
        end else begin
          e.we           = 4'b1100;
          e.wdata[31:16] = {data[7:0], data[15:8]};
        end
      end
      default: begin
        e.we    = 4'b1111;
        e.wdata = {data[7:0], data[15:8], data[23:16], data[31:24]};
      end
    endcase
    return e;
  endfunction

  sq_entry_t          mem [DEPTH];
  sq_entry_t          head_q, head_n, new_entry;
  logic [CNT_W-1:0]   count_q, count_n, remain;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_n, wr_ptr_q, wr_ptr_n;
  logic               req_q, req_n;
  logic               empty_q, empty_n;
  logic               not_full_q, not_full_n;
  logic               accept, misaligned, push, pop;

`ifdef ST_ALIGN_CHK_EN
  logic               ades_q, ades_n;
  logic [31:0]        badvaddr_q, badvaddr_n;
`endif

  // Next-state: handshake, pointer/count update and the head entry presented after the edge.
  always_comb begin
    accept     = sq.st_valid_i && sq.st_ready_o;
    misaligned = 1'b0;
`ifdef ST_ALIGN_CHK_EN
    misaligned = ((sq.st_size_i == 2'b01) && sq.st_addr_i[0]) ||
                 (sq.st_size_i[1] && (sq.st_addr_i[1:0] != 2'b00));
`endif
    push      = accept && !misaligned;
    pop       = req_q && sq.dm_ack_i;
    new_entry = format_store(sq.st_addr_i, sq.st_data_i, sq.st_size_i);

    remain     = count_q - CNT_W'(pop);
    count_n    = remain + CNT_W'(push);
    rd_ptr_n   = rd_ptr_q + PTR_W'(pop);
    wr_ptr_n   = wr_ptr_q + PTR_W'(push);
    req_n      = (count_n != '0);
    empty_n    = (count_n == '0);
    not_full_n = (count_n < CNT_W'(DEPTH));

    // An entry written this edge is not yet visible in mem, so forward it when it becomes head.
    head_n = '0;
    if (count_n != '0) begin
      if (remain == '0) head_n = new_entry;
      else              head_n = mem[rd_ptr_n];
    end

`ifdef ST_ALIGN_CHK_EN
    ades_n     = accept && misaligned;
    badvaddr_n = (accept && misaligned) ? sq.st_addr_i : badvaddr_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      head_q     <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      req_q      <= 1'b0;
      empty_q    <= 1'b1;
      not_full_q <= 1'b1;
`ifdef ST_ALIGN_CHK_EN
      ades_q     <= 1'b0;
      badvaddr_q <= '0;
`endif
    end else begin
      if (push) mem[wr_ptr_q] <= new_entry;
      head_q     <= head_n;
      count_q    <= count_n;
      rd_ptr_q   <= rd_ptr_n;
      wr_ptr_q   <= wr_ptr_n;
      req_q      <= req_n;
      empty_q    <= empty_n;
      not_full_q <= not_full_n;
`ifdef ST_ALIGN_CHK_EN
      ades_q     <= ades_n;
      badvaddr_q <= badvaddr_n;
`endif
    end
  end

  // Ready is held off for as long as reset is asserted, and rises in the first cycle after it drops.
  assign sq.st_ready_o = not_full_q && !rst;
  assign sq.dm_req_o   = req_q;
  assign sq.dm_addr_o  = {head_q.word_addr, 2'b00};
  assign sq.dm_we_o    = head_q.we;
  assign sq.dm_wdata_o = head_q.wdata;
  assign sq.sq_empty_o = empty_q;
  assign sq.sq_count_o = count_q;

`ifdef ST_ALIGN_CHK_EN
  assign sq.st_ades_o     = ades_q;
  assign sq.st_badvaddr_o = badvaddr_q;
`else
  assign sq.st_ades_o     = 1'b0;
  assign sq.st_badvaddr_o = '0;
`endif

endmodule

// File: tb/tb_store_queue.sv
// Directed bench for store_queue: table of single-store formatting vectors plus
// hand-written sequences for fill/drain, push+pop, reset mid-transfer and misalignment.
module tb_store_queue;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  store_queue_if sif();

  store_queue #(.DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .sq  (sif.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic [31:0] exp_addr;
    logic [3:0]  exp_we;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    sif.st_valid_i = 1'b0;
    sif.st_addr_i  = '0;
    sif.st_data_i  = '0;
    sif.st_size_i  = 2'b00;
  endtask

  task automatic offer(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    sif.st_valid_i = 1'b1;
    sif.st_addr_i  = a;
    sif.st_data_i  = d;
    sif.st_size_i  = s;
  endtask

  initial begin
    idle_inputs();
    sif.dm_ack_i = 1'b0;

    vecs[0] = '{32'h0000_0100, 32'h1122_3344, 2'b10, 32'h0000_0100, 4'b1111, 32'h4433_2211};
    vecs[1] = '{32'h0000_0203, 32'h0000_00AB, 2'b00, 32'h0000_0200, 4'b0001, 32'h0000_00AB};
    vecs[2] = '{32'h0000_0202, 32'h0000_BEEF, 2'b01, 32'h0000_0200, 4'b0011, 32'h0000_EFBE};
    vecs[3] = '{32'h0000_0300, 32'h1234_ABCD, 2'b01, 32'h0000_0300, 4'b1100, 32'hCDAB_0000};
    vecs[4] = '{32'h0000_0400, 32'hDEAD_BE5A, 2'b00, 32'h0000_0400, 4'b1000, 32'h5A00_0000};
    vecs[5] = '{32'h0000_0401, 32'h0000_0077, 2'b00, 32'h0000_0400, 4'b0100, 32'h0077_0000};
    vecs[6] = '{32'h0000_0402, 32'hFFFF_FF66, 2'b00, 32'h0000_0400, 4'b0010, 32'h0000_6600};
    vecs[7] = '{32'h0000_0500, 32'hA1B2_C3D4, 2'b11, 32'h0000_0500, 4'b1111, 32'hD4C3_B2A1};
    vecs[8] = '{32'hFFFF_FFFC, 32'h0102_0304, 2'b10, 32'hFFFF_FFFC, 4'b1111, 32'h0403_0201};
    vecs[9] = '{32'h8000_0010, 32'h0000_1357, 2'b01, 32'h8000_0010, 4'b1100, 32'h5713_0000};

    // Reset state, sampled while rst is still high.
    step();
    step();
    chk("rst_req",      32'(sif.dm_req_o),   32'h0);
    chk("rst_count",    32'(sif.sq_count_o), 32'h0);
    chk("rst_empty",    32'(sif.sq_empty_o), 32'h1);
    chk("rst_ready",    32'(sif.st_ready_o), 32'h0);
    chk("rst_we",       32'(sif.dm_we_o),    32'h0);
    chk("rst_addr",     sif.dm_addr_o,       32'h0);
    chk("rst_wdata",    sif.dm_wdata_o,      32'h0);
    chk("rst_ades",     32'(sif.st_ades_o),  32'h0);
    chk("rst_badvaddr", sif.st_badvaddr_o,   32'h0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(sif.st_ready_o), 32'h1);

    // Single stores with ack held high: visible next cycle, drained the cycle after.
    sif.dm_ack_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      offer(vecs[i].addr, vecs[i].data, vecs[i].size);
      step();
      idle_inputs();
      chk($sformatf("v%0d_req", i),   32'(sif.dm_req_o),   32'h1);
      chk($sformatf("v%0d_addr", i),  sif.dm_addr_o,       vecs[i].exp_addr);
      chk($sformatf("v%0d_we", i),    32'(sif.dm_we_o),    32'(vecs[i].exp_we));
      chk($sformatf("v%0d_wdata", i), sif.dm_wdata_o,      vecs[i].exp_wdata);
      step();
      chk($sformatf("v%0d_empty", i), 32'(sif.sq_empty_o), 32'h1);
      chk($sformatf("v%0d_we0", i),   32'(sif.dm_we_o),    32'h0);
    end

    // Fill: five words offered with ack low, only four accepted.
    sif.dm_ack_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      offer(32'h1000 + 32'(4 * i), 32'(i + 1), 2'b10);
      step();
      chk($sformatf("fill%0d_count", i), 32'(sif.sq_count_o), (i < 4) ? 32'(i + 1) : 32'd4);
      chk($sformatf("fill%0d_head", i),  sif.dm_addr_o,       32'h1000);
    end
    chk("full_ready", 32'(sif.st_ready_o), 32'h0);

    // Full queue with valid and ack together: pop only, then drain back-to-back.
    offer(32'h2000, 32'hCAFE_F00D, 2'b10);
    sif.dm_ack_i = 1'b1;
    step();
    idle_inputs();
    chk("fullpop_count", 32'(sif.sq_count_o), 32'd3);
    chk("fullpop_ready", 32'(sif.st_ready_o), 32'h1);
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("drain%0d_addr", i),  sif.dm_addr_o,  32'h1000 + 32'(4 * i));
      chk($sformatf("drain%0d_wdata", i), sif.dm_wdata_o, 32'(i + 1) << 24);
      step();
    end
    chk("drain_count", 32'(sif.sq_count_o), 32'd0);
    chk("drain_req",   32'(sif.dm_req_o),   32'h0);

    // Simultaneous push and pop keeps the count.
    offer(32'h3000, 32'hAAAA_0001, 2'b10);
    step();
    offer(32'h3004, 32'hBBBB_0002, 2'b10);
    step();
    idle_inputs();
    chk("pushpop_count", 32'(sif.sq_count_o), 32'd1);
    chk("pushpop_head",  sif.dm_addr_o,       32'h3004);
    chk("pushpop_wdata", sif.dm_wdata_o,      32'h0200_BBBB);
    step();
    chk("pushpop_empty", 32'(sif.sq_empty_o), 32'h1);

    // Reset pulse with three stores pending drops them all.
    sif.dm_ack_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      offer(32'h4000 + 32'(4 * i), 32'h55, 2'b10);
      step();
    end
    idle_inputs();
    chk("pre_rst_count", 32'(sif.sq_count_o), 32'd3);
    chk("pre_rst_req",   32'(sif.dm_req_o),   32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("mid_rst_req",   32'(sif.dm_req_o),   32'h0);
    chk("mid_rst_count", 32'(sif.sq_count_o), 32'd0);
    chk("mid_rst_ready", 32'(sif.st_ready_o), 32'h1);
    sif.dm_ack_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("post_rst_req%0d", i), 32'(sif.dm_req_o), 32'h0);
    end

    // Misaligned word store.
    offer(32'h0000_0102, 32'h1122_3344, 2'b10);
    step();
    idle_inputs();
`ifdef ST_ALIGN_CHK_EN
    chk("mis_req",      32'(sif.dm_req_o),   32'h0);
    chk("mis_ades",     32'(sif.st_ades_o),  32'h1);
    chk("mis_badvaddr", sif.st_badvaddr_o,   32'h0000_0102);
    step();
    chk("mis_ades_off", 32'(sif.st_ades_o),  32'h0);
    chk("mis_bad_hold", sif.st_badvaddr_o,   32'h0000_0102);
    chk("mis_count",    32'(sif.sq_count_o), 32'd0);
`else
    chk("mis_req",      32'(sif.dm_req_o),   32'h1);
    chk("mis_addr",     sif.dm_addr_o,       32'h0000_0100);
    chk("mis_we",       32'(sif.dm_we_o),    32'hF);
    chk("mis_wdata",    sif.dm_wdata_o,      32'h4433_2211);
    chk("mis_ades",     32'(sif.st_ades_o),  32'h0);
    chk("mis_badvaddr", sif.st_badvaddr_o,   32'h0);
    step();
    chk("mis_empty",    32'(sif.sq_empty_o), 32'h1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
